multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 174 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle FSM controller for a MIPS-style datapath. It sequences fetch, decode, execute, memory and writeback,
// times out stalled memory accesses, and counts retired instructions.
module multicycle_control_unit #(
  parameter int ENABLE_JUMP = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       instrOpCode,
  input  logic [5:0]       instrFunct,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             irWrite,
  output logic             iorD,
  output logic             beq,
  output logic             jump,
  output logic             shift,
  output logic             aluSrc,
  output logic             regDst,
  output logic             memToReg,
  output logic             regWrite,
  output logic             memWrite,
  output logic             memRead,
  output logic             loadFullWord,
  output logic             loadSigned,
  output logic             illegal,
  output logic             busError,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LH   = 6'h21;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_LHU  = 6'h25;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TMO_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  state_t             state_q, state_d;
  logic [5:0]         op_q, fn_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [CNT_W-1:0]   retired_q;
  logic               illegal_q, busError_q;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_ADDI, OP_LW, OP_LH, OP_LHU, OP_SW, OP_BEQ: op_legal = 1'b1;
      OP_J:    op_legal = (ENABLE_JUMP != 0);
      default: op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic fn_legal(input logic [5:0] fn);
    case (fn)
      6'h00, 6'h02, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: fn_legal = 1'b1;
      default: fn_legal = 1'b0;
    endcase
  endfunction

  logic dec_illegal, is_load, is_sw, is_r, is_addi, is_beq, is_j, wait_st, tmo_hit;

  // Legality is judged on the live fields in DECODE; everything later uses the latched copies.
  assign dec_illegal = !op_legal(instrOpCode) || ((instrOpCode == OP_R) && !fn_legal(instrFunct));
  assign is_load = (op_q == OP_LW) || (op_q == OP_LH) || (op_q == OP_LHU);
  assign is_sw   = (op_q == OP_SW);
  assign is_r    = (op_q == OP_R);
  assign is_addi = (op_q == OP_ADDI);
  assign is_beq  = (op_q == OP_BEQ);
  assign is_j    = (op_q == OP_J);
  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM);
  assign tmo_hit = (MEM_TIMEOUT > 0) && wait_st && !memReady && (wait_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (memReady) state_d = S_DECODE;
                else if (tmo_hit) state_d = S_HALT;
      S_DECODE: state_d = dec_illegal ? S_HALT : S_EXEC;
      S_EXEC:   if (is_beq || is_j) state_d = S_FETCH;
                else if (is_load || is_sw) state_d = S_MEM;
                else state_d = S_WB;
      S_MEM:    if (memReady) state_d = is_load ? S_WB : S_FETCH;
                else if (tmo_hit) state_d = S_HALT;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
    if (rst) state_d = S_FETCH;
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    if (rst) begin
      op_q       <= '0;
      fn_q       <= '0;
      wait_q     <= '0;
      retired_q  <= '0;
      illegal_q  <= 1'b0;
      busError_q <= 1'b0;
    end else begin
      if (state_q == S_DECODE) begin
        op_q <= instrOpCode;
        fn_q <= instrFunct;
      end
      // Any state change clears the wait count, so it always starts at zero on entry to FETCH or MEM.
      if (state_d != state_q) wait_q <= '0;
      else if (wait_st && !memReady && (wait_q != '1)) wait_q <= wait_q + 1'b1;
      if ((state_d == S_FETCH) && ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB))
          && (retired_q != '1))
        retired_q <= retired_q + 1'b1;
      if ((state_q == S_DECODE) && (state_d == S_HALT)) illegal_q <= 1'b1;
      if (wait_st && (state_d == S_HALT)) busError_q <= 1'b1;
    end
  end

  always_comb begin
    pcWrite = 1'b0; irWrite = 1'b0; iorD = 1'b0; beq = 1'b0; jump = 1'b0; shift = 1'b0;
    aluSrc = 1'b0; regDst = 1'b0; memToReg = 1'b0; regWrite = 1'b0; memWrite = 1'b0;
    memRead = 1'b0; loadFullWord = 1'b0; loadSigned = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          memRead = 1'b1;
          irWrite = memReady;
          pcWrite = memReady;
        end
        S_EXEC: begin
          aluSrc  = is_addi || is_load || is_sw;
          regDst  = !(is_addi || is_load || is_sw);
          shift   = is_r && ((fn_q == 6'h00) || (fn_q == 6'h02));
          beq     = is_beq;
          jump    = is_j;
          pcWrite = is_j;
        end
        S_MEM: begin
          iorD         = 1'b1;
          memRead      = is_load;
          memWrite     = is_sw;
          loadFullWord = (op_q == OP_LW);
          loadSigned   = (op_q == OP_LW) || (op_q == OP_LH);
        end
        S_WB: begin
          regWrite     = 1'b1;
          memToReg     = is_load;
          regDst       = is_r;
          loadFullWord = (op_q == OP_LW);
          loadSigned   = (op_q == OP_LW) || (op_q == OP_LH);
        end
        default: ;
      endcase
    end
  end

  assign illegal  = illegal_q;
  assign busError = busError_q;
  assign retired  = retired_q;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: two instances (jump on / timeout 4 / 16-bit counter and
// jump off / no timeout / 2-bit counter) share inputs; per-cycle expectations are queued and drained.
module tb_multicycle_control_unit;

  localparam logic [15:0] PCW = 16'h8000, IRW = 16'h4000, IORD = 16'h2000, BEQ = 16'h1000;
  localparam logic [15:0] JMP = 16'h0800, SHF = 16'h0400, ALU = 16'h0200, RD  = 16'h0100;
  localparam logic [15:0] MTR = 16'h0080, RW  = 16'h0040, MWR = 16'h0020, MRD = 16'h0010;
  localparam logic [15:0] LFW = 16'h0008, LS  = 16'h0004, ILL = 16'h0002, BUS = 16'h0001;
  localparam logic [15:0] FET = PCW | IRW | MRD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] instrOpCode = 6'h00;
  logic [5:0] instrFunct = 6'h00;
  logic       memReady = 1'b0;

  logic a_pcw, a_irw, a_iord, a_beq, a_jmp, a_shf, a_alu, a_rd, a_mtr, a_rw, a_mwr, a_mrd, a_lfw, a_ls, a_ill, a_bus;
  logic b_pcw, b_irw, b_iord, b_beq, b_jmp, b_shf, b_alu, b_rd, b_mtr, b_rw, b_mwr, b_mrd, b_lfw, b_ls, b_ill, b_bus;
  logic [15:0] a_ret;
  logic [1:0]  b_ret;
  logic [2:0]  a_state, b_state;
  logic [15:0] a_ctl, b_ctl;

  assign a_ctl = {a_pcw, a_irw, a_iord, a_beq, a_jmp, a_shf, a_alu, a_rd, a_mtr, a_rw, a_mwr, a_mrd, a_lfw, a_ls, a_ill, a_bus};
  assign b_ctl = {b_pcw, b_irw, b_iord, b_beq, b_jmp, b_shf, b_alu, b_rd, b_mtr, b_rw, b_mwr, b_mrd, b_lfw, b_ls, b_ill, b_bus};

  always #5 clk = ~clk;

  multicycle_control_unit #(.ENABLE_JUMP(1), .MEM_TIMEOUT(4), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .instrOpCode(instrOpCode), .instrFunct(instrFunct), .memReady(memReady),
    .pcWrite(a_pcw), .irWrite(a_irw), .iorD(a_iord), .beq(a_beq), .jump(a_jmp), .shift(a_shf),
    .aluSrc(a_alu), .regDst(a_rd), .memToReg(a_mtr), .regWrite(a_rw), .memWrite(a_mwr), .memRead(a_mrd),
    .loadFullWord(a_lfw), .loadSigned(a_ls), .illegal(a_ill), .busError(a_bus), .retired(a_ret), .state(a_state));

  multicycle_control_unit #(.ENABLE_JUMP(0), .MEM_TIMEOUT(0), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .instrOpCode(instrOpCode), .instrFunct(instrFunct), .memReady(memReady),
    .pcWrite(b_pcw), .irWrite(b_irw), .iorD(b_iord), .beq(b_beq), .jump(b_jmp), .shift(b_shf),
    .aluSrc(b_alu), .regDst(b_rd), .memToReg(b_mtr), .regWrite(b_rw), .memWrite(b_mwr), .memRead(b_mrd),
    .loadFullWord(b_lfw), .loadSigned(b_ls), .illegal(b_ill), .busError(b_bus), .retired(b_ret), .state(b_state));

  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        rdy;
    logic        chk;
    logic [2:0]  st;
    logic [15:0] ctl;
    int          ret;
    int          bst;
    logic [15:0] bctl;
    int          bret;
  } ent_t;

  ent_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Queue one cycle of stimulus with what both instances must show in that cycle (-1 = not checked).
  task automatic push(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                      input logic chk, input logic [2:0] st, input logic [15:0] ctl, input int ret = -1,
                      input int bst = -1, input logic [15:0] bctl = 16'h0, input int bret = -1);
    ent_t e;
    e.r = r; e.op = op; e.fn = fn; e.rdy = rdy; e.chk = chk; e.st = st; e.ctl = ctl;
    e.ret = ret; e.bst = bst; e.bctl = bctl; e.bret = bret;
    sb.push_back(e);
  endtask

  task automatic push_reset();
    push(1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 3'd0, 16'h0);
    push(1'b1, 6'h00, 6'h00, 1'b1, 1'b1, 3'd0, 16'h0, 0, 0, 16'h0, 0);
  endtask

  task automatic apply(input ent_t e);
    @(negedge clk);
    rst = e.r; instrOpCode = e.op; instrFunct = e.fn; memReady = e.rdy;
    #1;
  endtask

  task automatic test_reset();
    ent_t e;
    int k = 0;
    push_reset();
    push(1'b1, 6'h23, 6'h00, 1'b1, 1'b1, 3'd0, 16'h0, 0, 0, 16'h0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); apply(e);
      if (e.chk) begin n_vec++; if ({a_state, a_ctl} !== {e.st, e.ctl}) begin n_err++;
        $display("FAIL reset[%0d]: state/ctl got %0d/%h want %0d/%h", k, a_state, a_ctl, e.st, e.ctl); end end
      if (e.ret >= 0) begin n_vec++; if (a_ret !== 16'(e.ret)) begin n_err++;
        $display("FAIL reset[%0d]: retired got %0d want %0d", k, a_ret, e.ret); end end
      if (e.bst >= 0) begin n_vec++; if ({b_state, b_ctl} !== {3'(e.bst), e.bctl}) begin n_err++;
        $display("FAIL reset[%0d]: B state/ctl got %0d/%h want %0d/%h", k, b_state, b_ctl, e.bst, e.bctl); end end
      k++;
    end
  endtask

  task automatic test_lw();
    ent_t e;
    int k = 0;
    push_reset();
    push(1'b0, 6'h23, 6'h00, 1'b1, 1'b1, 3'd0, FET);
    push(1'b0, 6'h23, 6'h00, 1'b1, 1'b1, 3'd1, 16'h0);
    push(1'b0, 6'h23, 6'h00, 1'b1, 1'b1, 3'd2, ALU);
    push(1'b0, 6'h23, 6'h00, 1'b1, 1'b1, 3'd3, IORD | MRD | LFW | LS);
    push(1'b0, 6'h23, 6'h00, 1'b1, 1'b1, 3'd4, RW | MTR | LFW | LS);
    push(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 3'd0, MRD, 1, 0, MRD, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); apply(e);
      if (e.chk) begin n_vec++; if ({a_state, a_ctl} !== {e.st, e.ctl}) begin n_err++;
        $display("FAIL lw[%0d]: state/ctl got %0d/%h want %0d/%h", k, a_state, a_ctl, e.st, e.ctl); end end
      if (e.ret >= 0) begin n_vec++; if (a_ret !== 16'(e.ret)) begin n_err++;
        $display("FAIL lw[%0d]: retired got %0d want %0d", k, a_ret, e.ret); end end
      if (e.bst >= 0) begin n_vec++; if ({b_state, b_ctl} !== {3'(e.bst), e.bctl}) begin n_err++;
        $display("FAIL lw[%0d]: B state/ctl got %0d/%h want %0d/%h", k, b_state, b_ctl, e.bst, e.bctl); end end
      if (e.bret >= 0) begin n_vec++; if (b_ret !== 2'(e.bret)) begin n_err++;
        $display("FAIL lw[%0d]: B retired got %0d want %0d", k, b_ret, e.bret); end end
      k++;
    end
  endtask

  task automatic test_sw_wait();
    ent_t e;
    int k = 0;
    push_reset();
    push(1'b0, 6'h2B, 6'h00, 1'b1, 1'b1, 3'd0, FET);
    push(1'b0, 6'h2B, 6'h00, 1'b1, 1'b1, 3'd1, 16'h0);
    push(1'b0, 6'h2B, 6'h00, 1'b1, 1'b1, 3'd2, ALU);
    for (int i = 0; i < 3; i++) push(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 3'd3, IORD | MWR);
    push(1'b0, 6'h2B, 6'h00, 1'b1, 1'b1, 3'd3, IORD | MWR);
    push(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 3'd0, MRD, 1, 0, MRD, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); apply(e);
      if (e.chk) begin n_vec++; if ({a_state, a_ctl} !== {e.st, e.ctl}) begin n_err++;
        $display("FAIL sw_wait[%0d]: state/ctl got %0d/%h want %0d/%h", k, a_state, a_ctl, e.st, e.ctl); end end
      if (e.ret >= 0) begin n_vec++; if (a_ret !== 16'(e.ret)) begin n_err++;
        $display("FAIL sw_wait[%0d]: retired got %0d want %0d", k, a_ret, e.ret); end end
      if (e.bst >= 0) begin n_vec++; if ({b_state, b_ctl} !== {3'(e.bst), e.bctl}) begin n_err++;
        $display("FAIL sw_wait[%0d]: B state/ctl got %0d/%h want %0d/%h", k, b_state, b_ctl, e.bst, e.bctl); end end
      k++;
    end
  endtask

  task automatic test_illegal();
    ent_t e;
    int k = 0;
    push_reset();
    push(1'b0, 6'h3F, 6'h00, 1'b1, 1'b1, 3'd0, FET);
    push(1'b0, 6'h3F, 6'h00, 1'b1, 1'b1, 3'd1, 16'h0);
    push(1'b0, 6'h3F, 6'h00, 1'b1, 1'b1, 3'd5, ILL, 0, 5, ILL);
    push(1'b0, 6'h23, 6'h00, 1'b1, 1'b1, 3'd5, ILL);
    push(1'b1, 6'h23, 6'h00, 1'b1, 1'b1, 3'd5, ILL);
    push(1'b1, 6'h00, 6'h01, 1'b1, 1'b1, 3'd0, 16'h0, 0, 0, 16'h0);
    push(1'b0, 6'h00, 6'h01, 1'b1, 1'b1, 3'd0, FET);
    push(1'b0, 6'h00, 6'h01, 1'b1, 1'b1, 3'd1, 16'h0);
    push(1'b0, 6'h00, 6'h20, 1'b1, 1'b1, 3'd5, ILL, 0, 5, ILL);
    while (sb.size() > 0) begin
      e = sb.pop_front(); apply(e);
      if (e.chk) begin n_vec++; if ({a_state, a_ctl} !== {e.st, e.ctl}) begin n_err++;
        $display("FAIL illegal[%0d]: state/ctl got %0d/%h want %0d/%h", k, a_state, a_ctl, e.st, e.ctl); end end
      if (e.ret >= 0) begin n_vec++; if (a_ret !== 16'(e.ret)) begin n_err++;
        $display("FAIL illegal[%0d]: retired got %0d want %0d", k, a_ret, e.ret); end end
      if (e.bst >= 0) begin n_vec++; if ({b_state, b_ctl} !== {3'(e.bst), e.bctl}) begin n_err++;
        $display("FAIL illegal[%0d]: B state/ctl got %0d/%h want %0d/%h", k, b_state, b_ctl, e.bst, e.bctl); end end
      k++;
    end
  endtask

  task automatic test_jump();
    ent_t e;
    int k = 0;
    push_reset();
    push(1'b0, 6'h02, 6'h00, 1'b1, 1'b1, 3'd0, FET, -1, 0, FET);
    push(1'b0, 6'h02, 6'h00, 1'b1, 1'b1, 3'd1, 16'h0, -1, 1, 16'h0);
    push(1'b0, 6'h02, 6'h00, 1'b1, 1'b1, 3'd2, JMP | PCW | RD, 0, 5, ILL);
    push(1'b0, 6'h02, 6'h00, 1'b0, 1'b1, 3'd0, MRD, 1, 5, ILL, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); apply(e);
      if (e.chk) begin n_vec++; if ({a_state, a_ctl} !== {e.st, e.ctl}) begin n_err++;
        $display("FAIL jump[%0d]: state/ctl got %0d/%h want %0d/%h", k, a_state, a_ctl, e.st, e.ctl); end end
      if (e.ret >= 0) begin n_vec++; if (a_ret !== 16'(e.ret)) begin n_err++;
        $display("FAIL jump[%0d]: retired got %0d want %0d", k, a_ret, e.ret); end end
      if (e.bst >= 0) begin n_vec++; if ({b_state, b_ctl} !== {3'(e.bst), e.bctl}) begin n_err++;
        $display("FAIL jump[%0d]: B state/ctl got %0d/%h want %0d/%h", k, b_state, b_ctl, e.bst, e.bctl); end end
      if (e.bret >= 0) begin n_vec++; if (b_ret !== 2'(e.bret)) begin n_err++;
        $display("FAIL jump[%0d]: B retired got %0d want %0d", k, b_ret, e.bret); end end
      k++;
    end
  endtask

  task automatic test_timeout();
    ent_t e;
    int k = 0;
    push_reset();
    for (int i = 0; i < 4; i++) push(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, 3'd0, MRD, -1, 0, MRD);
    push(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, 3'd5, BUS, 0, 0, MRD);
    push(1'b0, 6'h08, 6'h00, 1'b1, 1'b1, 3'd5, BUS, 0, 0, FET);
    // memReady arriving on the last allowed wait cycle wins over the timeout; then a MEM-side timeout.
    push_reset();
    for (int i = 0; i < 3; i++) push(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 3'd0, MRD);
    push(1'b0, 6'h23, 6'h00, 1'b1, 1'b1, 3'd0, FET);
    push(1'b0, 6'h23, 6'h00, 1'b1, 1'b1, 3'd1, 16'h0);
    push(1'b0, 6'h23, 6'h00, 1'b1, 1'b1, 3'd2, ALU);
    for (int i = 0; i < 4; i++) push(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 3'd3, IORD | MRD | LFW | LS);
    push(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 3'd5, BUS, 0, 3, IORD | MRD | LFW | LS);
    while (sb.size() > 0) begin
      e = sb.pop_front(); apply(e);
      if (e.chk) begin n_vec++; if ({a_state, a_ctl} !== {e.st, e.ctl}) begin n_err++;
        $display("FAIL timeout[%0d]: state/ctl got %0d/%h want %0d/%h", k, a_state, a_ctl, e.st, e.ctl); end end
      if (e.ret >= 0) begin n_vec++; if (a_ret !== 16'(e.ret)) begin n_err++;
        $display("FAIL timeout[%0d]: retired got %0d want %0d", k, a_ret, e.ret); end end
      if (e.bst >= 0) begin n_vec++; if ({b_state, b_ctl} !== {3'(e.bst), e.bctl}) begin n_err++;
        $display("FAIL timeout[%0d]: B state/ctl got %0d/%h want %0d/%h", k, b_state, b_ctl, e.bst, e.bctl); end end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    ent_t e;
    int k = 0;
    push_reset();
    push(1'b0, 6'h04, 6'h00, 1'b1, 1'b1, 3'd0, FET);
    push(1'b0, 6'h04, 6'h00, 1'b1, 1'b1, 3'd1, 16'h0);
    push(1'b0, 6'h04, 6'h00, 1'b1, 1'b1, 3'd2, BEQ | RD);
    push(1'b0, 6'h00, 6'h00, 1'b1, 1'b1, 3'd0, FET, 1);
    push(1'b0, 6'h00, 6'h00, 1'b1, 1'b1, 3'd1, 16'h0);
    push(1'b0, 6'h3F, 6'h3F, 1'b1, 1'b1, 3'd2, SHF | RD);
    push(1'b0, 6'h3F, 6'h3F, 1'b1, 1'b1, 3'd4, RW | RD);
    push(1'b0, 6'h21, 6'h00, 1'b1, 1'b1, 3'd0, FET, 2);
    push(1'b0, 6'h21, 6'h00, 1'b1, 1'b1, 3'd1, 16'h0);
    push(1'b0, 6'h21, 6'h00, 1'b1, 1'b1, 3'd2, ALU);
    push(1'b0, 6'h21, 6'h00, 1'b1, 1'b1, 3'd3, IORD | MRD | LS);
    push(1'b0, 6'h21, 6'h00, 1'b1, 1'b1, 3'd4, RW | MTR | LS);
    push(1'b0, 6'h25, 6'h00, 1'b1, 1'b1, 3'd0, FET, 3);
    push(1'b0, 6'h25, 6'h00, 1'b1, 1'b1, 3'd1, 16'h0);
    push(1'b0, 6'h25, 6'h00, 1'b1, 1'b1, 3'd2, ALU);
    push(1'b0, 6'h25, 6'h00, 1'b1, 1'b1, 3'd3, IORD | MRD);
    push(1'b0, 6'h25, 6'h00, 1'b1, 1'b1, 3'd4, RW | MTR);
    push(1'b0, 6'h25, 6'h00, 1'b0, 1'b1, 3'd0, MRD, 4);
    while (sb.size() > 0) begin
      e = sb.pop_front(); apply(e);
      if (e.chk) begin n_vec++; if ({a_state, a_ctl} !== {e.st, e.ctl}) begin n_err++;
        $display("FAIL b2b[%0d]: state/ctl got %0d/%h want %0d/%h", k, a_state, a_ctl, e.st, e.ctl); end end
      if (e.ret >= 0) begin n_vec++; if (a_ret !== 16'(e.ret)) begin n_err++;
        $display("FAIL b2b[%0d]: retired got %0d want %0d", k, a_ret, e.ret); end end
      k++;
    end
  endtask

  task automatic test_retire_sat();
    ent_t e;
    int k = 0;
    push_reset();
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 6'h08, 6'h00, 1'b1, 1'b1, 3'd0, FET, i, -1, 16'h0, (i > 3) ? 3 : i);
      push(1'b0, 6'h08, 6'h00, 1'b1, 1'b1, 3'd1, 16'h0);
      push(1'b0, 6'h08, 6'h00, 1'b1, 1'b1, 3'd2, ALU);
      push(1'b0, 6'h08, 6'h00, 1'b1, 1'b1, 3'd4, RW);
    end
    push(1'b0, 6'h23, 6'h00, 1'b1, 1'b1, 3'd0, FET, 5, -1, 16'h0, 3);
    push(1'b0, 6'h23, 6'h00, 1'b1, 1'b1, 3'd1, 16'h0);
    push(1'b0, 6'h23, 6'h00, 1'b1, 1'b1, 3'd2, ALU);
    push(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 3'd3, IORD | MRD | LFW | LS);
    push(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, 3'd3, 16'h0, 5, 3, 16'h0, 3);
    push(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 3'd0, MRD, 0, 0, MRD, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); apply(e);
      if (e.chk) begin n_vec++; if ({a_state, a_ctl} !== {e.st, e.ctl}) begin n_err++;
        $display("FAIL retire_sat[%0d]: state/ctl got %0d/%h want %0d/%h", k, a_state, a_ctl, e.st, e.ctl); end end
      if (e.ret >= 0) begin n_vec++; if (a_ret !== 16'(e.ret)) begin n_err++;
        $display("FAIL retire_sat[%0d]: retired got %0d want %0d", k, a_ret, e.ret); end end
      if (e.bst >= 0) begin n_vec++; if ({b_state, b_ctl} !== {3'(e.bst), e.bctl}) begin n_err++;
        $display("FAIL retire_sat[%0d]: B state/ctl got %0d/%h want %0d/%h", k, b_state, b_ctl, e.bst, e.bctl); end end
      if (e.bret >= 0) begin n_vec++; if (b_ret !== 2'(e.bret)) begin n_err++;
        $display("FAIL retire_sat[%0d]: B retired got %0d want %0d", k, b_ret, e.bret); end end
      k++;
    end
  endtask

  initial begin
    @(posedge clk);
    test_reset();
    test_lw();
    test_sw_wait();
    test_illegal();
    test_jump();
    test_timeout();
    test_back_to_back();
    test_retire_sat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
